uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the board's UART link: the receiving counterpart to the existing transmitter. It samples an asynchronous serial line carrying frames of 1 start bit, 8 data bits LSB first, an even-parity bit and 1 stop bit at 11520 baud from the 100 MHz system clock. Each received byte is presented on a parallel bus with a one-cycle valid strobe and error flags. It feeds downstream byte consumers such as the LED command decoder.

## Interface
- CLKS_PER_BIT, 8681, system clocks per bit period (100 MHz / 11520); minimum 8.
- i_Clock  in  1  system clock; single clock domain; the block uses rising edges only.
- i_Reset  in  1  reset; synchronous, active-high.
- i_UART  in  1  asynchronous serial input; idle high.
- o_Data  out  8  last received byte; held until the next frame completes.
- o_Valid  out  1  one-cycle pulse when o_Data/flags update.
- o_ParityErr  out  1  parity mismatch on last frame; qualified by o_Valid, held until next o_Valid.
- o_FrameErr  out  1  stop bit sampled low on last frame; qualified by o_Valid, held until next o_Valid.

## Operation
- i_UART passes through a 2-flop synchronizer; all logic uses the synchronized value `rx`.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on `rx`=0, clear the bit counter, load the baud counter, and go to START. The "detect cycle" is the first IDLE cycle with `rx`=0.
- START: after H = floor(CLKS_PER_BIT/2) cycles, sample `rx`:
  - `rx`=1 is a false start (glitch); return to IDLE with no strobe.
  - Otherwise go to DATA.
- DATA: every CLKS_PER_BIT cycles, sample one bit into shift position [bitcount] (LSB first) and accumulate the XOR. After bit 7, go to PARITY.
- PARITY: sample after CLKS_PER_BIT cycles. The parity error is (XOR of the 8 data bits) ^ sample; non-zero means error. Go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - Next cycle: update o_Data and both flags, and pulse o_Valid.
  - If the stop bit was 1, go to IDLE.
  - If the stop bit was 0, set o_FrameErr and go to BREAK.
- BREAK: wait until `rx`=1, then go to IDLE. This prevents a held-low line from generating repeated frames.
- Error frames still strobe o_Valid; the consumer discards on a flag.
- Baud counter width: $clog2(CLKS_PER_BIT). It counts down to 0 and reloads with CLKS_PER_BIT-1.

## Timing
- Reset values: o_Data=0, o_Valid=0, o_ParityErr=0, o_FrameErr=0, state=IDLE, synchronizer flops=1.
- Sample points relative to the detect cycle D:
  - start bit: D+H
  - data bit k: D+H+(k+1)·CLKS_PER_BIT
  - parity: D+H+9·CLKS_PER_BIT
  - stop: D+H+10·CLKS_PER_BIT (D+H+9·CLKS_PER_BIT without parity)
- o_Valid is high at stop-sample+1 for exactly one cycle.
- Input-to-detect latency is 2 cycles (synchronizer).
- The return to IDLE happens mid-stop-bit, so back-to-back frames with no idle gap are received. Each frame resynchronizes on its own start edge.
- Reset mid-frame: abandon the frame immediately, produce no o_Valid, return all outputs to their reset values.

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state exists and a frame is 11 bits.
  - o_ParityErr is computed as above.
  - The project builds with this macro defined to match the transmitter.
- UART_RX_PARITY_EN undefined:
  - PARITY is removed; DATA goes directly to STOP and a frame is 10 bits.
  - o_ParityErr is tied to 0.

## Structure
- Shared package uart_pkg holds:
  - the state enum
  - UART_DATA_BITS=8
  - UART_CLKS_PER_BIT_100M=8681, which is also used by the transmitter's divider
- Sub-module uart_rx_sync: the 2-flop synchronizer, reset to 1, reusable for other async inputs.

## Test plan
Benches run with CLKS_PER_BIT=16 and the macro defined unless stated.
- Frame 0xA5, parity 0, stop 1 -> one o_Valid pulse at D+8+10·16+1; o_Data=0xA5; both flags 0.
- Frame 0x01 with parity 0 (wrong) -> o_Valid; o_Data=0x01; o_ParityErr=1; o_FrameErr=0.
- Frame 0x3C with stop 0, then line held low for 20 bit times -> one o_Valid with o_FrameErr=1 and no further strobes. After the line goes high, frame 0x81 -> o_Data=0x81 with flags 0.
- Low glitch of 4 cycles -> no o_Valid; state back in IDLE; the next frame 0x5A is received correctly.
- Back-to-back 0x55 then 0xAA with no gap -> two o_Valid pulses exactly 176 cycles apart with correct data. Repeat with the macro undefined -> 160 cycles apart.
- i_Reset pulsed during data bit 3 -> no o_Valid; outputs are 0 the cycle after reset; the following frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions used by the receiver and the transmitter
//
// Contents:
//   UART_DATA_BITS          data bits per frame
//   UART_CLKS_PER_BIT_100M  100 MHz clocks per bit at 11520 baud (also the transmitter divider)
//   uart_state_e            receiver state encoding
package uart_pkg;

   localparam int UART_DATA_BITS         = 8;
   localparam int UART_CLKS_PER_BIT_100M = 8681;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte bus from the UART receiver to a byte consumer
//
// Signals:
//   o_Data       last received byte
//   o_Valid      one-cycle strobe when o_Data and the flags update
//   o_ParityErr  parity mismatch on the last frame, qualified by o_Valid
//   o_FrameErr   stop bit sampled low on the last frame, qualified by o_Valid
// Modports: master (receiver drives), slave (consumer reads).
interface uart_rx_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] o_Data;
   logic                      o_Valid;
   logic                      o_ParityErr;
   logic                      o_FrameErr;

   modport master (output o_Data, output o_Valid, output o_ParityErr, output o_FrameErr);
   modport slave  (input  o_Data, input  o_Valid, input  o_ParityErr, input  o_FrameErr);

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for an asynchronous idle-high input
//
// Ports:
//   i_Clock  destination clock (rising edge)
//   i_Reset  synchronous active-high reset; both flops reset to 1 (idle level)
//   i_Async  asynchronous input
//   o_Sync   synchronized copy of i_Async, two cycles later
module uart_rx_sync (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Async,
   output logic o_Sync
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], i_Async};
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign o_Sync = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 1 start, 8 data LSB first, optional even parity, 1 stop
//
// Build option: UART_RX_PARITY_EN adds the even-parity bit (11-bit frame);
// without it the frame is 10 bits and o_ParityErr stays 0.
//
// Ports:
//   i_Clock  system clock, rising edge
//   i_Reset  synchronous active-high reset
//   i_UART   asynchronous serial input, idle high
//   rx_bus   received byte, valid strobe and error flags (uart_rx_if.master)
// Parameter:
//   CLKS_PER_BIT  system clocks per bit period, minimum 8
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_100M
) (
   input  logic         i_Clock,
   input  logic         i_Reset,
   input  logic         i_UART,
   uart_rx_if.master    rx_bus
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(UART_DATA_BITS);
   localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
   // Start-bit wait is half a bit, so every later sample lands mid-bit.
   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(UART_DATA_BITS - 1);

   logic rx;

   uart_rx_sync u_sync (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_Async (i_UART),
      .o_Sync  (rx)
   );

   uart_state_e               state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [BIT_W-1:0]          bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [UART_DATA_BITS-1:0] data_q, data_d;
   logic                      valid_q, valid_d;
   logic                      perr_q, perr_d;
   logic                      ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                      xor_q, xor_d;
   logic                      frame_perr_q, frame_perr_d;
`endif

   logic tick;
   assign tick = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
      xor_d        = xor_q;
      frame_perr_d = frame_perr_q;
`endif
      case (state_q)
         IDLE: begin
            if (!rx) begin
               bit_d   = '0;
               cnt_d   = HALF_RELOAD;
`ifdef UART_RX_PARITY_EN
               xor_d   = 1'b0;
`endif
               state_d = START;
            end
         end
         START: begin
            if (!tick) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (rx) begin
               // Line is high again at mid start bit: treat as a glitch.
               state_d = IDLE;
            end else begin
               cnt_d   = BIT_RELOAD;
               state_d = DATA;
            end
         end
         DATA: begin
            if (!tick) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               shift_d[bit_q] = rx;
`ifdef UART_RX_PARITY_EN
               xor_d = xor_q ^ rx;
`endif
               cnt_d = BIT_RELOAD;
               if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (!tick) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               frame_perr_d = xor_q ^ rx;
               cnt_d        = BIT_RELOAD;
               state_d      = STOP;
            end
         end
`endif
         STOP: begin
            if (!tick) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               data_d  = shift_q;
               valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               perr_d  = frame_perr_q;
`else
               perr_d  = 1'b0;
`endif
               ferr_d  = !rx;
               // Leaving mid-stop-bit lets a following start edge be caught
               // with no idle gap; a low stop waits out the break instead.
               state_d = rx ? IDLE : BREAK;
            end
         end
         BREAK: begin
            if (rx) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         xor_q        <= 1'b0;
         frame_perr_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         xor_q        <= xor_d;
         frame_perr_q <= frame_perr_d;
`endif
      end
   end

   assign rx_bus.o_Data      = data_q;
   assign rx_bus.o_Valid     = valid_q;
   assign rx_bus.o_ParityErr = perr_q;
   assign rx_bus.o_FrameErr  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (CLKS_PER_BIT=16)
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPB = 16;
   localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int FRAME_BITS = PAR_EN ? 11 : 10;
   // Drive edge to o_Valid: 2 sync + 1 detect + H + (frame bits - 1) bit periods.
   localparam int LAT = 3 + H + (FRAME_BITS - 1) * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   uart_rx_if bus ();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock (clk),
      .i_Reset (rst),
      .i_UART  (uart),
      .rx_bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] at;
      logic [7:0]  data;
      logic        perr;
      logic        ferr;
   } rec_t;

   rec_t vq[$];
   logic prev_v = 1'b0;
   int   wide_pulses = 0;

   always @(negedge clk) begin
      if (bus.o_Valid === 1'b1) begin
         vq.push_back({32'(cyc), bus.o_Data, bus.o_ParityErr, bus.o_FrameErr});
         if (prev_v) wide_pulses++;
      end
      prev_v = (bus.o_Valid === 1'b1);
   end

   task automatic bit_time(input logic v);
      uart = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle(input int n);
      uart = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop, output int n0);
      n0 = cyc;
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      if (PAR_EN) bit_time((^d) ^ ~par_ok);
      bit_time(stop);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      uart = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.o_Data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.o_Data); end
      checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.o_Valid); end
      checks++; if (bus.o_ParityErr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %0b expected 0", bus.o_ParityErr); end
      checks++; if (bus.o_FrameErr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %0b expected 0", bus.o_FrameErr); end
      rst = 1'b0;
      idle(20);
   endtask

   task automatic test_good_frame;
      int n0;
      vq.delete();
      send_frame(8'hA5, 1'b1, 1'b1, n0);
      idle(CPB);
      checks++; if (vq.size() !== 1) begin errors++; $display("FAIL good_count: got %0d expected 1", vq.size()); end
      if (vq.size() >= 1) begin
         checks++; if (vq[0].at !== 32'(n0 + LAT)) begin errors++; $display("FAIL good_latency: got %0d expected %0d", vq[0].at - 32'(n0), LAT); end
         checks++; if (vq[0].data !== 8'hA5) begin errors++; $display("FAIL good_data: got %0h expected a5", vq[0].data); end
         checks++; if ({vq[0].perr, vq[0].ferr} !== 2'b00) begin errors++; $display("FAIL good_flags: got %0b expected 00", {vq[0].perr, vq[0].ferr}); end
      end
   endtask

   task automatic test_parity_error;
      int n0;
      vq.delete();
      send_frame(8'h01, 1'b0, 1'b1, n0);
      idle(CPB);
      checks++; if (vq.size() !== 1) begin errors++; $display("FAIL par_count: got %0d expected 1", vq.size()); end
      if (vq.size() >= 1) begin
         checks++; if (vq[0].data !== 8'h01) begin errors++; $display("FAIL par_data: got %0h expected 01", vq[0].data); end
         checks++; if (vq[0].perr !== PAR_EN) begin errors++; $display("FAIL par_perr: got %0b expected %0b", vq[0].perr, PAR_EN); end
         checks++; if (vq[0].ferr !== 1'b0) begin errors++; $display("FAIL par_ferr: got %0b expected 0", vq[0].ferr); end
      end
   endtask

   task automatic test_break;
      int n0;
      vq.delete();
      send_frame(8'h3C, 1'b1, 1'b0, n0);
      uart = 1'b0;
      repeat (20 * CPB) @(negedge clk);
      idle(3 * CPB);
      checks++; if (vq.size() !== 1) begin errors++; $display("FAIL brk_count: got %0d expected 1", vq.size()); end
      if (vq.size() >= 1) begin
         checks++; if (vq[0].data !== 8'h3C) begin errors++; $display("FAIL brk_data: got %0h expected 3c", vq[0].data); end
         checks++; if ({vq[0].perr, vq[0].ferr} !== 2'b01) begin errors++; $display("FAIL brk_flags: got %0b expected 01", {vq[0].perr, vq[0].ferr}); end
      end
      vq.delete();
      send_frame(8'h81, 1'b1, 1'b1, n0);
      idle(CPB);
      checks++; if (vq.size() !== 1) begin errors++; $display("FAIL after_brk_count: got %0d expected 1", vq.size()); end
      if (vq.size() >= 1) begin
         checks++; if (vq[0].data !== 8'h81) begin errors++; $display("FAIL after_brk_data: got %0h expected 81", vq[0].data); end
         checks++; if ({vq[0].perr, vq[0].ferr} !== 2'b00) begin errors++; $display("FAIL after_brk_flags: got %0b expected 00", {vq[0].perr, vq[0].ferr}); end
      end
   endtask

   task automatic test_glitch;
      int n0;
      vq.delete();
      uart = 1'b0;
      repeat (4) @(negedge clk);
      idle(3 * CPB);
      checks++; if (vq.size() !== 0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", vq.size()); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", dut.state_q, IDLE); end
      send_frame(8'h5A, 1'b1, 1'b1, n0);
      idle(CPB);
      checks++; if (vq.size() !== 1) begin errors++; $display("FAIL glitch_next_count: got %0d expected 1", vq.size()); end
      if (vq.size() >= 1) begin
         checks++; if (vq[0].data !== 8'h5A) begin errors++; $display("FAIL glitch_next_data: got %0h expected 5a", vq[0].data); end
         checks++; if ({vq[0].perr, vq[0].ferr} !== 2'b00) begin errors++; $display("FAIL glitch_next_flags: got %0b expected 00", {vq[0].perr, vq[0].ferr}); end
      end
   endtask

   task automatic test_back_to_back;
      int n0, n1;
      vq.delete();
      send_frame(8'h55, 1'b1, 1'b1, n0);
      send_frame(8'hAA, 1'b1, 1'b1, n1);
      idle(CPB);
      checks++; if (vq.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", vq.size()); end
      if (vq.size() >= 2) begin
         checks++; if (vq[1].at - vq[0].at !== 32'(FRAME_BITS * CPB)) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", vq[1].at - vq[0].at, FRAME_BITS * CPB); end
         checks++; if (vq[0].data !== 8'h55) begin errors++; $display("FAIL b2b_data0: got %0h expected 55", vq[0].data); end
         checks++; if (vq[1].data !== 8'hAA) begin errors++; $display("FAIL b2b_data1: got %0h expected aa", vq[1].data); end
         checks++; if ({vq[0].perr, vq[0].ferr, vq[1].perr, vq[1].ferr} !== 4'b0000) begin errors++; $display("FAIL b2b_flags: got %0b expected 0000", {vq[0].perr, vq[0].ferr, vq[1].perr, vq[1].ferr}); end
      end
   endtask

   task automatic test_reset_mid_frame;
      int n0;
      logic [7:0] d;
      d = 8'h3C;
      vq.delete();
      bit_time(1'b0);
      for (int i = 0; i < 3; i++) bit_time(d[i]);
      uart = d[3];
      repeat (H) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      uart = 1'b1;
      checks++; if (bus.o_Data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %0h expected 0", bus.o_Data); end
      checks++; if ({bus.o_Valid, bus.o_ParityErr, bus.o_FrameErr} !== 3'b000) begin errors++; $display("FAIL rstmid_flags: got %0b expected 000", {bus.o_Valid, bus.o_ParityErr, bus.o_FrameErr}); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected %0d", dut.state_q, IDLE); end
      idle(12 * CPB);
      checks++; if (vq.size() !== 0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", vq.size()); end
      send_frame(8'hC3, 1'b1, 1'b1, n0);
      idle(CPB);
      checks++; if (vq.size() !== 1) begin errors++; $display("FAIL rstmid_next_count: got %0d expected 1", vq.size()); end
      if (vq.size() >= 1) begin
         checks++; if (vq[0].data !== 8'hC3) begin errors++; $display("FAIL rstmid_next_data: got %0h expected c3", vq[0].data); end
         checks++; if ({vq[0].perr, vq[0].ferr} !== 2'b00) begin errors++; $display("FAIL rstmid_next_flags: got %0b expected 00", {vq[0].perr, vq[0].ferr}); end
      end
      checks++; if (wide_pulses !== 0) begin errors++; $display("FAIL valid_width: got %0d multi-cycle pulses expected 0", wide_pulses); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity_error();
      test_break();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
